// File: rtl/pipe_pkg.sv
// Shared pipeline-stage definitions: stage state encodings, boot address, default counter width.
// No logic; imported by every stage register and its helpers.
package pipe_pkg;

    typedef enum logic [1:0] {
        PS_EMPTY = 2'b00,
        PS_BUSY  = 2'b01,
        PS_FULL  = 2'b10
    } pipe_state_e;

    localparam logic [31:0] BOOT_ADDRESS = 32'h0000_0000;
    localparam int          PIPE_CNT_W   = 16;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating event counter: +1 per cycle with inc_in high, sticks at all-ones; 1-cycle update.
// No backpressure; cleared only by the asynchronous active-low reset.
module pipe_sat_counter
    import pipe_pkg::*;
#(
    parameter int CNT_W = PIPE_CNT_W
) (
    input  logic             clk_in,
    input  logic             reset_in,
    input  logic             inc_in,
    output logic [CNT_W-1:0] cnt_out
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_in && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_out = cnt_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Handshaked pipeline stage with 2-entry skid buffer and flush; 1-cycle latency, 1 beat/cycle,
// up_ready_out is a pure flop decode (no dn_ready_in path). PIPE_STATS_EN adds stall/flush counters.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int                DATA_W    = 32,
    parameter logic [DATA_W-1:0] RESET_VAL = {DATA_W{1'b0}},
    parameter int                CNT_W     = PIPE_CNT_W
) (
    input  logic              clk_in,
    input  logic              reset_in,
    input  logic              up_valid_in,
    output logic              up_ready_out,
    input  logic [DATA_W-1:0] up_data_in,
    output logic              dn_valid_out,
    input  logic              dn_ready_in,
    output logic [DATA_W-1:0] dn_data_reg_out,
    input  logic              flush_in
`ifdef PIPE_STATS_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt_out,
    output logic [CNT_W-1:0]  flush_cnt_out
`endif
);

    pipe_state_e       state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              up_fire;
    logic              dn_fire;

    assign dn_valid_out    = (state_q != PS_EMPTY);
    assign up_ready_out    = (state_q != PS_FULL);
    assign dn_data_reg_out = main_q;

    assign up_fire = up_valid_in & up_ready_out;
    assign dn_fire = dn_valid_out & dn_ready_in;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            PS_EMPTY: begin
                if (up_fire) begin
                    main_d  = up_data_in;
                    state_d = PS_BUSY;
                end
            end
            PS_BUSY: begin
                if (up_fire && dn_fire) begin
                    main_d = up_data_in;
                end else if (up_fire) begin
                    skid_d  = up_data_in;
                    state_d = PS_FULL;
                end else if (dn_fire) begin
                    state_d = PS_EMPTY;
                end
            end
            PS_FULL: begin
                if (dn_fire) begin
                    main_d  = skid_q;
                    state_d = PS_BUSY;
                end
            end
            default: state_d = PS_EMPTY;
        endcase
        // Flush kills validity only; payload flops keep whatever they held.
        if (flush_in) begin
            state_d = PS_EMPTY;
            main_d  = main_q;
            skid_d  = skid_q;
        end
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            state_q <= PS_EMPTY;
            main_q  <= RESET_VAL;
            skid_q  <= RESET_VAL;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

`ifdef PIPE_STATS_EN
    pipe_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk_in   (clk_in),
        .reset_in (reset_in),
        .inc_in   (dn_valid_out & ~dn_ready_in),
        .cnt_out  (stall_cnt_out)
    );

    pipe_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk_in   (clk_in),
        .reset_in (reset_in),
        .inc_in   (flush_in),
        .cnt_out  (flush_cnt_out)
    );
`endif

endmodule
